// File: rtl/sim_sup_pkg.sv
// Shared types and constants for the end-of-simulation supervisor.
// Holds the FSM state encoding, the verdict codes and the halt-policy selectors.
package sim_sup_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    V_NONE    = 2'd0,
    V_PASS    = 2'd1,
    V_TIMEOUT = 2'd2,
    V_ERROR   = 2'd3
  } verdict_t;

  localparam int HALT_ALL_SAME_LANE = 0;
  localparam int HALT_ALL_STICKY    = 1;
  localparam int HALT_ANY           = 2;

endpackage

// File: rtl/halt_policy.sv
// Reduces the per-monitor halt lanes to a single run-complete indication.
// The sticky flags remember which monitors have halted since the last run start.
module halt_policy
  import sim_sup_pkg::*;
#(
  parameter int NUM_MON   = 2,
  parameter int NUM_LANE  = 8,
  parameter int HALT_MODE = HALT_ALL_SAME_LANE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic [NUM_MON*NUM_LANE-1:0] halt,
  output logic                        halt_hit
);

  logic [NUM_MON-1:0]  r_sticky;
  logic [NUM_MON-1:0]  w_mon_any;
  logic [NUM_LANE-1:0] w_lane_all;

  // NOTE: every signal written here gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_mon_any  = '0;
    w_lane_all = '1;
    for (int m = 0; m < NUM_MON; m++) begin
      w_mon_any[m] = |halt[m*NUM_LANE +: NUM_LANE];
      w_lane_all   = w_lane_all & halt[m*NUM_LANE +: NUM_LANE];
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= '0;
    end else if (clear) begin
      r_sticky <= '0;
    end else begin
      r_sticky <= r_sticky | w_mon_any;
    end
  end

  // The current-cycle halts are ORed in so the last monitor to halt completes the set immediately.
  always_comb begin
    case (HALT_MODE)
      HALT_ALL_SAME_LANE: halt_hit = |w_lane_all;
      HALT_ALL_STICKY:    halt_hit = &(r_sticky | w_mon_any);
      default:            halt_hit = |halt;
    endcase
  end

endmodule

// File: rtl/sim_run_supervisor.sv
// End-of-simulation supervisor: runs a timeout budget, watches halts and errors,
// and raises one finish request with a classified verdict.
module sim_run_supervisor
  import sim_sup_pkg::*;
#(
  parameter int NUM_MON      = 2,
  parameter int NUM_LANE     = 8,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 5,
  parameter int HALT_MODE    = HALT_ALL_SAME_LANE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_W-1:0]            timeout_cycles,
  input  logic [NUM_MON*NUM_LANE-1:0] halt,
  input  logic [NUM_MON-1:0]          mon_error,
  input  logic                        mem_error,
  output logic                        running,
  output logic                        finish_req,
  output logic [1:0]                  verdict,
  output logic [NUM_MON:0]            err_src,
  output logic [CNT_W-1:0]            cycle_count
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  verdict_t           r_verdict;
  verdict_t           w_verdict_nxt;
  logic [CNT_W-1:0]   r_tcnt;
  logic [DCNT_W-1:0]  r_dcnt;
  logic [NUM_MON:0]   r_err_src;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               w_start_ok;
  logic               w_err_any;
  logic               w_halt_hit;

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_err_any  = mem_error | (|mon_error);

  halt_policy #(
    .NUM_MON  (NUM_MON),
    .NUM_LANE (NUM_LANE),
    .HALT_MODE(HALT_MODE)
  ) u_halt_policy (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_start_ok),
    .halt    (halt),
    .halt_hit(w_halt_hit)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_verdict_nxt = r_verdict;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_err_any) begin
          w_state_nxt = S_DRAIN;
        end else if (w_halt_hit) begin
          w_state_nxt   = S_DONE;
          w_verdict_nxt = V_PASS;
        end else if (r_tcnt == '0) begin
          w_state_nxt   = S_DONE;
          w_verdict_nxt = V_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == '0) begin
          w_state_nxt   = S_DONE;
          w_verdict_nxt = V_ERROR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_verdict     <= V_NONE;
      r_tcnt        <= '0;
      r_dcnt        <= '0;
      r_err_src     <= '0;
      r_cycle_count <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_verdict <= w_verdict_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tcnt        <= timeout_cycles;
            r_cycle_count <= '0;
          end
        end
        S_RUN: begin
          if (w_err_any) begin
            r_err_src <= {mem_error, mon_error};
            r_dcnt    <= DCNT_W'(DRAIN_CYCLES - 1);
          end else if (!w_halt_hit && (r_tcnt != '0)) begin
            r_tcnt <= r_tcnt - CNT_W'(1);
          end
        end
        S_DRAIN: if (r_dcnt != '0) r_dcnt <= r_dcnt - DCNT_W'(1);
        default: ;
      endcase
      if (running && !(&r_cycle_count)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  assign running     = (r_state == S_RUN) || (r_state == S_DRAIN);
  // The request is raised in the deciding cycle, so it pulses exactly once as DONE is entered.
  assign finish_req  = (r_state != S_DONE) && (w_state_nxt == S_DONE);
  assign verdict     = r_verdict;
  assign err_src     = r_err_src;
  assign cycle_count = r_cycle_count;

endmodule

// File: doc/sim_run_supervisor.md
Name: sim_run_supervisor

Overview:
Parametrised end-of-simulation supervisor for the top-level bench, driving the dual-core (ooo + pipeline) and later multi-core runs. Watches N monitor interfaces' halt lanes, N monitor error flags and the banked-memory error flag, and counts cycles against a load-time timeout. Issues one finish request with a classified verdict. Generalises the bench's fixed two-monitor, eight-lane halt check with a selectable halt policy, a configurable post-error drain and a run-cycle counter.

Parameters:
NUM_MON, 2, number of monitored cores/monitor interfaces
NUM_LANE, 8, halt lanes per monitor (commit width)
CNT_W, 32, width of timeout and cycle counters
DRAIN_CYCLES, 5, cycles held between error detection and finish request (>=1)
HALT_MODE, 0, 0 = all monitors halt on the same lane in the same cycle; 1 = every monitor has halted at some point (sticky per monitor); 2 = any monitor halts

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; begins a run from IDLE, ignored otherwise
timeout_cycles  in  CNT_W  run budget, sampled on accepted start
halt  in  NUM_MON*NUM_LANE  halt lanes; monitor m lane l = bit m*NUM_LANE+l
mon_error  in  NUM_MON  per-monitor error flag
mem_error  in  1  banked-memory error flag
running  out  1  high in RUN and DRAIN
finish_req  out  1  single-cycle pulse on entry to DONE
verdict  out  2  0 none, 1 pass (halt), 2 timeout, 3 error; valid in DONE
err_src  out  NUM_MON+1  captured error vector {mem_error, mon_error} at detection
cycle_count  out  CNT_W  RUN+DRAIN cycles elapsed, saturating at all-ones

Behaviour:
- Reset (async assert, sync release): state IDLE; running=0, finish_req=0, verdict=0, err_src=0, cycle_count=0, sticky halt flags=0, timeout counter=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on start load tcnt=timeout_cycles, clear cycle_count and sticky flags, go RUN next cycle.
- RUN, evaluated each cycle in priority order:
  - any mon_error or mem_error -> capture err_src, load dcnt=DRAIN_CYCLES-1, go DRAIN.
  - halt condition true -> verdict=1, go DONE.
  - tcnt==0 -> verdict=2, go DONE.
  - otherwise tcnt decrements.
- Halt condition:
  - mode 0: OR over l of AND over m of halt[m][l].
  - mode 1: sticky[m] |= |halt[m]; condition = &(sticky | current halts), so the final halt counts in the same cycle.
  - mode 2: |halt.
- timeout_cycles==0: timeout fires on the first RUN cycle unless an error or halt is present that cycle.
- DRAIN: further errors or halts ignored; err_src holds its first capture. At dcnt==0 set verdict=3 and go DONE, else decrement. An error in RUN cycle k yields finish_req in cycle k+DRAIN_CYCLES.
- DONE: finish_req high only on the entry cycle. Verdict, err_src and cycle_count hold. Absorbing; start ignored; only rst leaves it.
- cycle_count increments in RUN and DRAIN and saturates.
- Reset mid-run returns to IDLE immediately with no finish_req.

Decomposition:
- Shared package sim_sup_pkg: state enum (IDLE/RUN/DRAIN/DONE), verdict enum (V_NONE/V_PASS/V_TIMEOUT/V_ERROR), HALT_MODE constants.
- One sub-module, halt_policy: combinational reduction of halt plus per-monitor sticky flags; inputs clk, rst, clear, halt; output halt_hit; parametrised by NUM_MON, NUM_LANE, HALT_MODE.

Test Plan:
- Mode 0, NUM_MON=2: start, timeout=100; cycle 10 mon0 lane3 only; cycle 20 both lane3 -> finish_req in cycle 20 of RUN, verdict=1, cycle_count=21.
- Mode 0: mon0 lane2 and mon1 lane5 halt together -> no finish; timeout=50 -> verdict=2, finish_req after 51 RUN cycles.
- Mode 1: mon0 halts cycle 5, mon1 halts cycle 30 -> verdict=1 at cycle 30; mode 2 same stimulus -> verdict=1 at cycle 5.
- mem_error at RUN cycle 7, mon_error[1] at cycle 9 -> err_src=3'b100, finish_req at cycle 12 (DRAIN_CYCLES=5), verdict=3.
- Same-cycle error+halt+tcnt==0 -> error wins (DRAIN); timeout_cycles=0 with no events -> verdict=2 on first RUN cycle.
- Assert rst in DRAIN -> all outputs zero asynchronously, no finish_req; new start runs normally; start during DONE ignored.
